// File: rtl/logic_reduce_pkg.sv
// Shared op encodings and per-op helpers for the pipelined word reducer.
package logic_reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    // Value that leaves any operand unchanged when folded with the op's base.
    function automatic logic identity(input op_t op);
        return (op == OP_AND);
    endfunction

    // NOR reduces as OR; the inversion is applied once at the output.
    function automatic op_t base_of(input op_t op);
        return (op == OP_NOR) ? OP_OR : op;
    endfunction

    function automatic logic fold(input op_t base, input logic a, input logic b);
        logic r;
        case (base)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = a | b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_reduce_pipe_group.sv
// Combinational GROUP-bit base reducer with popcount; one slice of stage 1.
module reduce_group
    import logic_reduce_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0]           bits,
    input  logic [1:0]                 base,
    output logic                       partial,
    output logic [$clog2(GROUP+1)-1:0] count
);

    localparam int GCW = $clog2(GROUP + 1);

    op_t base_op;
    assign base_op = op_t'(base);

    // NOTE: every variable driven here gets a value before any conditional
    // logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        partial = identity(base_op);
        count   = '0;
        for (int i = 0; i < GROUP; i++) begin
            partial = fold(base_op, partial, bits[i]);
            count   = count + GCW'(bits[i]);
        end
    end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Two-stage valid/ready word reducer (OR/AND/XOR/NOR) with popcount and an
// optional running accumulator that folds successive words together.
module logic_reduce_pipe
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 in_op,
    input  logic                       in_acc,
    input  logic                       in_clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_f,
    output logic [$clog2(WIDTH+1)-1:0] out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int NG  = WIDTH / GROUP;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int GCW = $clog2(GROUP + 1);

    if (WIDTH < 2 || (WIDTH % GROUP) != 0) begin : g_param_check
        $error("logic_reduce_pipe: WIDTH must be >= 2 and a multiple of GROUP");
    end

    // ---------------- stage 1 partial reducers ----------------
    op_t                     in_op_e;
    op_t                     in_base;
    logic [NG-1:0]           grp_partial;
    logic [NG-1:0][GCW-1:0]  grp_count;

    assign in_op_e = op_t'(in_op);
    assign in_base = base_of(in_op_e);

    for (genvar g = 0; g < NG; g++) begin : g_group
        reduce_group #(
            .GROUP (GROUP)
        ) u_group (
            .bits    (in_data[g*GROUP +: GROUP]),
            .base    (in_base),
            .partial (grp_partial[g]),
            .count   (grp_count[g])
        );
    end

    // ---------------- flow control ----------------
    logic ready_en;
    logic s1_valid;
    logic s2_advance;
    logic s1_advance;
    logic in_xfer;

    assign s2_advance = !out_valid | out_ready;
    assign s1_advance = s1_valid & s2_advance;
    assign in_ready   = ready_en & (!s1_valid | s1_advance);
    assign in_xfer    = in_valid & in_ready;

    // ---------------- stage 1 payload ----------------
    logic [NG-1:0]          s1_partial;
    logic [NG-1:0][GCW-1:0] s1_count;
    op_t                    s1_op;
    logic                   s1_acc;
    logic                   s1_clr;

    // NOTE: payload registers carry no reset; s1_valid alone decides whether
    // their contents are meaningful, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_partial <= grp_partial;
            s1_count   <= grp_count;
            s1_op      <= in_op_e;
            s1_acc     <= in_acc;
            s1_clr     <= in_clr;
        end
    end

    // ---------------- stage 2 combine and accumulate ----------------
    logic           acc_reg;
    op_t            last_op;
    op_t            s1_base;
    logic           word_base;
    logic [CW-1:0]  word_count;
    logic           acc_src;
    logic           acc_next;
    logic           f_next;

    always_comb begin
        s1_base    = base_of(s1_op);
        word_base  = identity(s1_base);
        word_count = '0;
        for (int g = 0; g < NG; g++) begin
            word_base  = fold(s1_base, word_base, s1_partial[g]);
            word_count = word_count + CW'(s1_count[g]);
        end
        // An explicit clear or a change of op restarts from the op's identity.
        acc_src  = (s1_clr || (s1_op != last_op)) ? identity(s1_op) : acc_reg;
        acc_next = fold(s1_base, acc_src, word_base);
        f_next   = (s1_acc ? acc_next : word_base) ^ (s1_op == OP_NOR);
    end

    // ---------------- control, output and accumulator state ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_f     <= 1'b0;
            out_count <= '0;
            acc_reg   <= 1'b0;
            last_op   <= OP_OR;
        end else begin
            ready_en <= 1'b1;
            if (!s1_valid || s1_advance) begin
                s1_valid <= in_xfer;
            end
            if (s2_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_f     <= f_next;
                    out_count <= word_count;
                    if (s1_acc) begin
                        acc_reg <= acc_next;
                        last_op <= s1_op;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench: three instances (WIDTH 2, 8, 16) checked against a word-level model.
module tb_logic_reduce_pipe;
    import logic_reduce_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       f;
        logic [4:0] cnt;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t q2[$];
    exp_t q8[$];
    exp_t q16[$];

    logic       macc8  = 1'b0, macc16  = 1'b0, macc2  = 1'b0;
    logic [1:0] mlast8 = 2'd0, mlast16 = 2'd0, mlast2 = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level reference: reduce the masked word, then apply accumulate rules.
    function automatic void model(input int w, input logic [15:0] d, input logic [1:0] op,
                                  input logic acc, input logic clr,
                                  inout logic macc, inout logic [1:0] mlast,
                                  output logic f, output logic [4:0] cnt);
        logic [15:0] mask, dd;
        logic b, src, r;
        mask = 16'((32'd1 << w) - 32'd1);
        dd   = d & mask;
        cnt  = 5'($countones(dd));
        case (op)
            2'd1:    b = (dd == mask);
            2'd2:    b = ^dd;
            default: b = |dd;
        endcase
        if (!acc) begin
            f = b ^ (op == 2'd3);
        end else begin
            src = (clr || op != mlast) ? (op == 2'd1) : macc;
            case (op)
                2'd1:    r = src & b;
                2'd2:    r = src ^ b;
                default: r = src | b;
            endcase
            macc  = r;
            mlast = op;
            f     = r ^ (op == 2'd3);
        end
    endfunction

    // ---------------- WIDTH=2 instance ----------------
    logic [1:0] d2_data = '0;
    logic [1:0] d2_op = '0;
    logic d2_acc = 0, d2_clr = 0, d2_valid = 0, d2_oready = 1;
    logic d2_iready, d2_f, d2_ovalid;
    logic [1:0] d2_cnt;

    logic_reduce_pipe #(.WIDTH(2), .GROUP(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(d2_data), .in_op(d2_op), .in_acc(d2_acc),
        .in_clr(d2_clr), .in_valid(d2_valid), .in_ready(d2_iready), .out_f(d2_f),
        .out_count(d2_cnt), .out_valid(d2_ovalid), .out_ready(d2_oready));

    // ---------------- WIDTH=8 instance ----------------
    logic [7:0] d8_data = '0;
    logic [1:0] d8_op = '0;
    logic d8_acc = 0, d8_clr = 0, d8_valid = 0, d8_oready = 1;
    logic d8_iready, d8_f, d8_ovalid;
    logic [3:0] d8_cnt;

    logic_reduce_pipe #(.WIDTH(8), .GROUP(4)) dut8 (
        .clk(clk), .rst(rst), .in_data(d8_data), .in_op(d8_op), .in_acc(d8_acc),
        .in_clr(d8_clr), .in_valid(d8_valid), .in_ready(d8_iready), .out_f(d8_f),
        .out_count(d8_cnt), .out_valid(d8_ovalid), .out_ready(d8_oready));

    // ---------------- WIDTH=16 instance ----------------
    logic [15:0] d16_data = '0;
    logic [1:0] d16_op = '0;
    logic d16_acc = 0, d16_clr = 0, d16_valid = 0, d16_oready = 1;
    logic d16_iready, d16_f, d16_ovalid;
    logic [4:0] d16_cnt;

    logic_reduce_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst(rst), .in_data(d16_data), .in_op(d16_op), .in_acc(d16_acc),
        .in_clr(d16_clr), .in_valid(d16_valid), .in_ready(d16_iready), .out_f(d16_f),
        .out_count(d16_cnt), .out_valid(d16_ovalid), .out_ready(d16_oready));

    // ---------------- monitors (sample on the falling edge) ----------------
    exp_t e2, e8, e16;
    logic hold8v = 1'b0;
    logic hold8f;
    logic [3:0] hold8c;

    always @(negedge clk) begin
        if (!rst && d2_ovalid && d2_oready) begin
            if (q2.size() == 0) check("q2_unexpected", d2_ovalid, 0);
            else begin
                e2 = q2.pop_front();
                check("out2_f", d2_f, e2.f);
                check("out2_cnt", d2_cnt, e2.cnt);
                if (e2.lat) check("lat2", cyc - e2.cyc, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) hold8v = 1'b0;
        else begin
            if (hold8v) begin
                check("hold8_valid", d8_ovalid, 1);
                check("hold8_f", d8_f, hold8f);
                check("hold8_cnt", d8_cnt, hold8c);
            end
            hold8v = d8_ovalid && !d8_oready;
            hold8f = d8_f;
            hold8c = d8_cnt;
            if (d8_ovalid && d8_oready) begin
                if (q8.size() == 0) check("q8_unexpected", d8_ovalid, 0);
                else begin
                    e8 = q8.pop_front();
                    check("out8_f", d8_f, e8.f);
                    check("out8_cnt", d8_cnt, e8.cnt);
                    if (e8.lat) check("lat8", cyc - e8.cyc, 2);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d16_ovalid && d16_oready) begin
            if (q16.size() == 0) check("q16_unexpected", d16_ovalid, 0);
            else begin
                e16 = q16.pop_front();
                check("out16_f", d16_f, e16.f);
                check("out16_cnt", d16_cnt, e16.cnt);
            end
        end
    end

    // ---------------- drivers (inputs change 1 time unit after the rising edge) ----------------
    task automatic send2(input logic [1:0] d, input logic [1:0] op);
        logic f;
        logic [4:0] c;
        d2_data = d; d2_op = op; d2_acc = 0; d2_clr = 0; d2_valid = 1;
        @(negedge clk);
        check("t1_ready2", d2_iready, 1);
        if (d2_iready) begin
            model(2, {14'h0, d}, op, 1'b0, 1'b0, macc2, mlast2, f, c);
            q2.push_back('{f: f, cnt: c, cyc: cyc, lat: 1'b1});
        end
        @(posedge clk); #1;
        d2_valid = 0;
    endtask

    task automatic send8(input logic [7:0] d, input logic [1:0] op, input logic acc,
                         input logic clr, input bit lat, input bit expect_ready);
        int n = 0;
        logic f;
        logic [4:0] c;
        d8_data = d; d8_op = op; d8_acc = acc; d8_clr = clr; d8_valid = 1;
        @(negedge clk);
        if (expect_ready) check("nobubble8", d8_iready, 1);
        while (!d8_iready && n < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!d8_iready) check("send8_timeout", d8_iready, 1);
        else begin
            model(8, {8'h0, d}, op, acc, clr, macc8, mlast8, f, c);
            q8.push_back('{f: f, cnt: c, cyc: cyc, lat: lat});
        end
        @(posedge clk); #1;
        d8_valid = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q2.size() + q8.size() + q16.size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, q2.size() + q8.size() + q16.size(), 0);
    endtask

    logic [7:0] w3 [5] = '{8'h11, 8'h80, 8'h3C, 8'hFF, 8'h00};
    logic [1:0] o3 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        int accepted;
        int sent;
        int n;
        logic f;
        logic [4:0] c;
        logic xfer;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_f", d8_f, 0);
        check("rst_cnt", d8_cnt, 0);
        check("rst_valid", d8_ovalid, 0);
        check("rst_ready_low", d8_iready, 0);
        rst = 0;
        @(posedge clk); #1;
        check("rst_ready_high", d8_iready, 1);

        // 1: WIDTH=2 OR truth table
        for (int i = 0; i < 4; i++) send2(2'(i), 2'(OP_OR));
        drain("t1_drain");

        // 2: every op on A5, back to back, checked latency
        send8(8'hA5, 2'(OP_OR),  0, 0, 1, 1);
        send8(8'hA5, 2'(OP_AND), 0, 0, 1, 1);
        send8(8'hA5, 2'(OP_XOR), 0, 0, 1, 1);
        send8(8'hA5, 2'(OP_NOR), 0, 0, 1, 1);
        drain("t2_drain");

        // 3: backpressure
        d8_oready = 0;
        accepted  = 0;
        for (int k = 0; k < 6; k++) begin
            if (accepted < 5) begin
                d8_data = w3[accepted]; d8_op = o3[accepted];
                d8_acc = 0; d8_clr = 0; d8_valid = 1;
            end
            @(negedge clk);
            if (d8_valid && d8_iready) begin
                model(8, {8'h0, d8_data}, d8_op, 1'b0, 1'b0, macc8, mlast8, f, c);
                q8.push_back('{f: f, cnt: c, cyc: cyc, lat: 1'b0});
                accepted++;
            end
            @(posedge clk); #1;
        end
        check("t3_accepted", accepted, 2);
        check("t3_stalled", d8_iready, 0);
        d8_valid  = 0;
        d8_oready = 1;
        for (int k = 2; k < 5; k++) send8(w3[k], o3[k], 0, 0, 0, 0);
        drain("t3_drain");

        // 4: XOR accumulate then op change
        send8(8'h01, 2'(OP_XOR), 1, 1, 1, 1);
        send8(8'h03, 2'(OP_XOR), 1, 0, 1, 1);
        send8(8'h07, 2'(OP_XOR), 1, 0, 1, 1);
        send8(8'hFF, 2'(OP_AND), 1, 0, 1, 1);
        drain("t4_drain");

        // 5: reset with two accumulate words in flight and the output stalled
        d8_oready = 0;
        send8(8'h01, 2'(OP_XOR), 1, 1, 0, 0);
        send8(8'h02, 2'(OP_XOR), 1, 0, 0, 0);
        rst = 1;
        #1;
        check("t5_valid", d8_ovalid, 0);
        check("t5_f", d8_f, 0);
        check("t5_cnt", d8_cnt, 0);
        q8.delete();
        macc8 = 1'b0; mlast8 = 2'd0;
        @(posedge clk); #1;
        rst = 0;
        d8_oready = 1;
        send8(8'h01, 2'(OP_XOR), 1, 0, 0, 0);
        drain("t5_drain");

        // 6: WIDTH=16 random traffic
        sent = 0;
        n    = 0;
        while (sent < 1000 && n < 20000) begin
            d16_oready = ($urandom_range(0, 3) != 0);
            if (!d16_valid && $urandom_range(0, 3) != 0) begin
                d16_data  = 16'($urandom);
                d16_op    = 2'($urandom);
                d16_acc   = 1'($urandom);
                d16_clr   = ($urandom_range(0, 7) == 0);
                d16_valid = 1;
            end
            @(negedge clk);
            xfer = d16_valid && d16_iready;
            if (xfer) begin
                model(16, d16_data, d16_op, d16_acc, d16_clr, macc16, mlast16, f, c);
                q16.push_back('{f: f, cnt: c, cyc: cyc, lat: 1'b0});
                sent++;
            end
            @(posedge clk); #1;
            if (xfer) d16_valid = 0;
            n++;
        end
        check("t6_sent", sent, 1000);
        d16_valid  = 0;
        d16_oready = 1;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
